alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_ctrl_pkg.sv | 65 ++++++
 rtl/btn_sync_edge.sv | 43 ++++
 rtl/alu_seq_ctrl.sv | 82 ++++++++
 tb/tb_alu_seq_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : alu_ctrl_pkg
// Brief  : Shared types, step codes and FSM helper functions for the ALU
//          operand-entry sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    LOAD_A  = 3'd1,
    WAIT_B  = 3'd2,
    LOAD_B  = 3'd3,
    WAIT_OP = 3'd4,
    LOAD_OP = 3'd5,
    EVAL    = 3'd6,
    SHOW    = 3'd7
  } state_t;

  localparam logic [1:0] STEP_A   = 2'd0;
  localparam logic [1:0] STEP_B   = 2'd1;
  localparam logic [1:0] STEP_OP  = 2'd2;
  localparam logic [1:0] STEP_RES = 2'd3;

  // Cancel dominates enter everywhere except EVAL, where the update pulse is
  // allowed to finish and the cancel only redirects the exit to WAIT_A.
  function automatic state_t next_state(input state_t cur,
                                        input logic   enter_rise,
                                        input logic   cancel_rise);
    state_t nxt;
    nxt = cur;
    if (cancel_rise && (cur != EVAL)) begin
      nxt = WAIT_A;
    end else begin
      case (cur)
        WAIT_A:  nxt = enter_rise  ? LOAD_A  : WAIT_A;
        LOAD_A:  nxt = WAIT_B;
        WAIT_B:  nxt = enter_rise  ? LOAD_B  : WAIT_B;
        LOAD_B:  nxt = WAIT_OP;
        WAIT_OP: nxt = enter_rise  ? LOAD_OP : WAIT_OP;
        LOAD_OP: nxt = EVAL;
        EVAL:    nxt = cancel_rise ? WAIT_A  : SHOW;
        SHOW:    nxt = enter_rise  ? LOAD_A  : SHOW;
        default: nxt = WAIT_A;
      endcase
    end
    return nxt;
  endfunction

  // Entry-phase indicator shown to the user for a given state.
  function automatic logic [1:0] step_of(input state_t s);
    logic [1:0] code;
    case (s)
      WAIT_A, LOAD_A:   code = STEP_A;
      WAIT_B, LOAD_B:   code = STEP_B;
      WAIT_OP, LOAD_OP: code = STEP_OP;
      default:          code = STEP_RES;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : btn_sync_edge
// Brief  : Multi-flop synchronizer plus rising-edge detector for a debounced
//          button. A button already held when reset releases is ignored until
//          it has been seen low once.
// Rev    : 1.0  initial release
// ============================================================================
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic [SYNC_STAGES-1:0] fill;
  logic                   prev;
  logic                   armed;

  // Shift the button through the synchronizer; 'fill' marks when the chain
  // holds a genuinely sampled value, and 'armed' latches once that value is low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync  <= '0;
      fill  <= '0;
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], btn};
      fill  <= {fill[SYNC_STAGES-2:0], 1'b1};
      prev  <= sync[SYNC_STAGES-1];
      armed <= armed | (fill[SYNC_STAGES-1] & ~sync[SYNC_STAGES-1]);
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~prev & armed;

endmodule
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : alu_seq_ctrl
// Brief  : Button-driven sequencer that steps operand A, operand B and the
//          OpCode into the ALU register wrapper, then captures the result.
// Rev    : 1.0  initial release
// ============================================================================
module alu_seq_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enter,
  input  logic             cancel,
  output logic             load_A,
  output logic             load_B,
  output logic             load_Op,
  output logic             updateRes,
  output logic [1:0]       step,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic   enter_rise;
  logic   cancel_rise;
  state_t state;
  state_t nxt;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_enter_sync (
    .clock (clock),
    .reset (reset),
    .btn   (enter),
    .rise  (enter_rise)
  );

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cancel_sync (
    .clock (clock),
    .reset (reset),
    .btn   (cancel),
    .rise  (cancel_rise)
  );

  // Next-state selection from the current state and the two button pulses.
  always_comb begin
    nxt = next_state(state, enter_rise, cancel_rise);
  end

  // State register with outputs registered from the next state, so every
  // output equals a pure decode of the state it accompanies.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= WAIT_A;
      load_A    <= 1'b0;
      load_B    <= 1'b0;
      load_Op   <= 1'b0;
      updateRes <= 1'b0;
      busy      <= 1'b0;
      step      <= STEP_A;
      op_count  <= '0;
    end else begin
      state     <= nxt;
      load_A    <= (nxt == LOAD_A);
      load_B    <= (nxt == LOAD_B);
      load_Op   <= (nxt == LOAD_OP);
      updateRes <= (nxt == EVAL);
      busy      <= (nxt == LOAD_A) || (nxt == LOAD_B) ||
                   (nxt == LOAD_OP) || (nxt == EVAL);
      step      <= step_of(nxt);
      if (state == EVAL) begin
        op_count <= op_count + CNT_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_alu_seq_ctrl
// Brief  : Directed self-checking bench for the ALU entry sequencer.
// Rev    : 1.0  initial release
// ============================================================================
module tb_alu_seq_ctrl;

  logic       clock;
  logic       reset;
  logic       enter;
  logic       cancel;
  logic       load_A;
  logic       load_B;
  logic       load_Op;
  logic       updateRes;
  logic [1:0] step;
  logic       busy;
  logic [7:0] op_count;

  int checks = 0;
  int errors = 0;

  alu_seq_ctrl #(.SYNC_STAGES(2), .CNT_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .enter     (enter),
    .cancel    (cancel),
    .load_A    (load_A),
    .load_B    (load_B),
    .load_Op   (load_Op),
    .updateRes (updateRes),
    .step      (step),
    .busy      (busy),
    .op_count  (op_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [3:0] pv();
    return {load_A, load_B, load_Op, updateRes};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Press enter from a waiting state; the load pulse must appear one cycle
  // after the synchronized rise (third edge after the press).
  task automatic enter_press(input string tag, input logic [3:0] exp_pulse,
                             input logic [1:0] exp_step);
    enter = 1'b1;
    tick();
    tick();
    chk({tag, "_pre"}, 32'(pv()), 32'h0);
    tick();
    chk({tag, "_pulse"}, 32'(pv()), 32'(exp_pulse));
    chk({tag, "_step"}, 32'(step), 32'(exp_step));
    chk({tag, "_busy"}, 32'(busy), 32'h1);
    enter = 1'b0;
  endtask

  task automatic qpress();
    enter = 1'b1;
    repeat (3) tick();
    enter = 1'b0;
    repeat (3) tick();
  endtask

  // Pulse outputs must be mutually exclusive every cycle.
  always @(negedge clock) begin
    if (!reset) begin
      checks++;
      assert ($onehot0(pv())) else begin
        errors++;
        $error("FAIL onehot observed=%b expected=at_most_one", pv());
      end
    end
  end

  initial begin
    int n;
    reset  = 1'b0;
    enter  = 1'b0;
    cancel = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_pulses", 32'(pv()), 32'h0);
    chk("rst_step", 32'(step), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cnt", 32'(op_count), 32'h0);
    @(posedge clock);
    @(posedge clock);
    #3 reset = 1'b0;
    repeat (5) tick();
    chk("idle_step", 32'(step), 32'h0);

    // Full entry sequence
    enter_press("seqA", 4'b1000, 2'd0);
    tick(); chk("seqA_next", 32'(step), 32'h1); chk("seqA_idle", 32'(busy), 32'h0);
    tick();
    enter_press("seqB", 4'b0100, 2'd1);
    tick(); chk("seqB_next", 32'(step), 32'h2);
    tick();
    enter_press("seqOp", 4'b0010, 2'd2);
    tick();
    chk("seq_upd", 32'(pv()), 32'h1);
    chk("seq_upd_step", 32'(step), 32'h3);
    chk("seq_upd_busy", 32'(busy), 32'h1);
    tick();
    chk("show_pulses", 32'(pv()), 32'h0);
    chk("show_step", 32'(step), 32'h3);
    chk("show_busy", 32'(busy), 32'h0);
    chk("show_cnt", 32'(op_count), 32'h1);
    repeat (3) tick();
    chk("show_hold", 32'(step), 32'h3);
    enter_press("again", 4'b1000, 2'd0);
    tick(); chk("again_next", 32'(step), 32'h1);

    // Cancel back to WAIT_A, then hold enter for 50 cycles
    cancel = 1'b1;
    repeat (3) tick();
    chk("cancel_step", 32'(step), 32'h0);
    cancel = 1'b0;
    repeat (3) tick();
    enter = 1'b1;
    n = 0;
    repeat (50) begin
      tick();
      if (load_A) n++;
    end
    chk("held_loads", 32'(n), 32'h1);
    chk("held_step", 32'(step), 32'h1);
    enter = 1'b0;
    repeat (3) tick();

    // Simultaneous enter and cancel in WAIT_OP
    enter_press("toOp", 4'b0100, 2'd1);
    tick(); chk("toOp_next", 32'(step), 32'h2);
    tick();
    enter  = 1'b1;
    cancel = 1'b1;
    tick();
    tick();
    chk("both_pre", 32'(pv()), 32'h0);
    tick();
    chk("both_pulses", 32'(pv()), 32'h0);
    chk("both_step", 32'(step), 32'h0);
    tick();
    chk("both_hold", 32'(step), 32'h0);
    enter  = 1'b0;
    cancel = 1'b0;
    repeat (3) tick();

    // Cancel whose rise lands in EVAL
    enter_press("dA", 4'b1000, 2'd0);
    tick(); tick();
    enter_press("dB", 4'b0100, 2'd1);
    tick(); tick();
    enter = 1'b1;
    tick();
    tick();
    cancel = 1'b1;
    tick();
    chk("def_loadop", 32'(pv()), 32'h2);
    enter = 1'b0;
    tick();
    chk("def_upd", 32'(pv()), 32'h1);
    chk("def_upd_step", 32'(step), 32'h3);
    tick();
    chk("def_pulses", 32'(pv()), 32'h0);
    chk("def_step", 32'(step), 32'h0);
    chk("def_busy", 32'(busy), 32'h0);
    chk("def_cnt", 32'(op_count), 32'h2);
    cancel = 1'b0;
    tick();
    chk("def_hold", 32'(step), 32'h0);
    repeat (3) tick();

    // Reset between edges during LOAD_B, with enter still held afterwards
    enter_press("rA", 4'b1000, 2'd0);
    tick(); tick();
    enter = 1'b1;
    repeat (3) tick();
    chk("mid_loadb", 32'(load_B), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_loadb", 32'(load_B), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_step", 32'(step), 32'h0);
    chk("mid_rst_cnt", 32'(op_count), 32'h0);
    @(posedge clock);
    @(posedge clock);
    #3 reset = 1'b0;
    n = 0;
    repeat (10) begin
      tick();
      if (pv() != 4'b0000) n++;
    end
    chk("held_reset_pulses", 32'(n), 32'h0);
    chk("held_reset_step", 32'(step), 32'h0);
    enter = 1'b0;
    repeat (3) tick();
    enter_press("post", 4'b1000, 2'd0);
    tick(); chk("post_next", 32'(step), 32'h1);

    // 256 complete evaluations: counter wraps
    cancel = 1'b1;
    repeat (3) tick();
    cancel = 1'b0;
    repeat (3) tick();
    chk("wrap_start", 32'(step), 32'h0);
    for (int i = 1; i <= 256; i++) begin
      qpress();
      qpress();
      qpress();
      if (i == 1)   chk("wrap_1", 32'(op_count), 32'h1);
      if (i == 255) chk("wrap_255", 32'(op_count), 32'd255);
      if (i == 256) chk("wrap_256", 32'(op_count), 32'h0);
    end
    chk("wrap_step", 32'(step), 32'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
